// File: rtl/debouncer_multi.sv
// Multi-channel push-button debouncer.
// Each channel synchronises its raw input, qualifies level changes with a
// live-programmable stability threshold, and emits rise/fall pulses plus a
// single long-press pulse after LONG_CYCLES of continuous debounced high.
module debouncer_multi #(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [CNT_W-1:0] threshold_i,
  input  logic [N_CH-1:0]  bounced_i,
  output logic [N_CH-1:0]  debounced_o,
  output logic [N_CH-1:0]  rise_o,
  output logic [N_CH-1:0]  fall_o,
  output logic [N_CH-1:0]  long_o
);

  typedef enum logic [1:0] {
    LOW      = 2'd0,
    CHK_HIGH = 2'd1,
    HIGH     = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);

  // Threshold widened by one bit so the "count + 1" comparison never
  // overflows; zero is treated as one.
  logic [CNT_W:0] thr_eff;

  // Effective threshold, shared by all channels and sampled every cycle.
  always_comb begin
    thr_eff = {1'b0, threshold_i};
    if (threshold_i == '0) begin
      thr_eff = (CNT_W + 1)'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_reg;
      state_t                 state_reg;
      logic [CNT_W-1:0]       stab_reg;
      logic [CNT_W-1:0]       hold_reg;
      logic                   deb_reg;
      logic                   rise_reg;
      logic                   fall_reg;
      logic                   long_reg;

      logic                   sync_bit;
      logic [CNT_W-1:0]       stab_next;
      logic                   accept_next;

      assign sync_bit = sync_reg[SYNC_STAGES-1];

      // Saturating stability increment and acceptance test. The first
      // differing cycle already counts, so a threshold of 1 accepts
      // straight out of a settled state.
      always_comb begin
        stab_next   = (stab_reg == CNT_MAX) ? stab_reg : stab_reg + 1'b1;
        accept_next = (({1'b0, stab_reg} + (CNT_W + 1)'(1)) >= thr_eff);
      end

      // Input synchroniser chain; free-running regardless of enable.
      always_ff @(posedge clock) begin
        if (reset) begin
          sync_reg <= '0;
        end else begin
          sync_reg <= {sync_reg[SYNC_STAGES-2:0], bounced_i[gi]};
        end
      end

      // Debounce FSM with stability/hold counters and registered pulses.
      always_ff @(posedge clock) begin
        if (reset) begin
          state_reg <= LOW;
          stab_reg  <= '0;
          hold_reg  <= '0;
          deb_reg   <= 1'b0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          long_reg  <= 1'b0;
        end else if (!enable) begin
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
          long_reg  <= 1'b0;
        end else begin
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
          long_reg <= 1'b0;

          case (state_reg)
            LOW: begin
              if (sync_bit) begin
                if (accept_next) begin
                  state_reg <= HIGH;
                  stab_reg  <= '0;
                  deb_reg   <= 1'b1;
                  rise_reg  <= 1'b1;
                end else begin
                  state_reg <= CHK_HIGH;
                  stab_reg  <= stab_next;
                end
              end
            end
            CHK_HIGH: begin
              if (!sync_bit) begin
                state_reg <= LOW;
                stab_reg  <= '0;
              end else if (accept_next) begin
                state_reg <= HIGH;
                stab_reg  <= '0;
                deb_reg   <= 1'b1;
                rise_reg  <= 1'b1;
              end else begin
                stab_reg  <= stab_next;
              end
            end
            HIGH: begin
              if (!sync_bit) begin
                if (accept_next) begin
                  state_reg <= LOW;
                  stab_reg  <= '0;
                  deb_reg   <= 1'b0;
                  fall_reg  <= 1'b1;
                end else begin
                  state_reg <= CHK_LOW;
                  stab_reg  <= stab_next;
                end
              end
            end
            default: begin // CHK_LOW
              if (sync_bit) begin
                state_reg <= HIGH;
                stab_reg  <= '0;
              end else if (accept_next) begin
                state_reg <= LOW;
                stab_reg  <= '0;
                deb_reg   <= 1'b0;
                fall_reg  <= 1'b1;
              end else begin
                stab_reg  <= stab_next;
              end
            end
          endcase

          // Hold counter saturates at the limit so long_o fires once per press.
          if (!deb_reg) begin
            hold_reg <= '0;
          end else if (hold_reg != LONG_LIM) begin
            hold_reg <= hold_reg + 1'b1;
            if (hold_reg + 1'b1 == LONG_LIM) begin
              long_reg <= 1'b1;
            end
          end
        end
      end

      assign debounced_o[gi] = deb_reg;
      assign rise_o[gi]      = rise_reg;
      assign fall_o[gi]      = fall_reg;
      assign long_o[gi]      = long_reg;
    end
  endgenerate

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi: expected output events are queued
// when stimulus is applied and compared against the DUT each cycle.
module tb_debouncer_multi;

  localparam int N_CH        = 4;
  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int LONG_CYCLES = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b1;
  logic [CNT_W-1:0] thr = 16'd8;
  logic [N_CH-1:0]  bounced = '0;
  logic [N_CH-1:0]  deb;
  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  lng;

  always #10 clk = ~clk;

  debouncer_multi #(
    .N_CH(N_CH),
    .CNT_W(CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .LONG_CYCLES(LONG_CYCLES)
  ) dut (
    .clock(clk),
    .reset(rst),
    .enable(enable),
    .threshold_i(thr),
    .bounced_i(bounced),
    .debounced_o(deb),
    .rise_o(rise),
    .fall_o(fall),
    .long_o(lng)
  );

  typedef struct {
    int         cyc;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lng;
    logic [3:0] deb;
    string      tag;
  } ev_t;

  ev_t        sb[$];
  ev_t        mon_ev;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] plan_deb = 4'b0;
  logic [3:0] exp_deb = 4'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp_v);
    end
  endtask

  // Monitor: pop the event due this cycle, otherwise require silence.
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_ev = sb.pop_front();
        checks++;
        assert (mon_ev.cyc >= cyc) else begin
          errors++;
          $error("FAIL stale_%s cyc=%0d observed=missed expected_cyc=%0d", mon_ev.tag, cyc, mon_ev.cyc);
        end
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        mon_ev = sb.pop_front();
        exp_deb = mon_ev.deb;
        $display("event %s cyc=%0d deb=%b rise=%b fall=%b long=%b", mon_ev.tag, cyc, deb, rise, fall, lng);
        chk({mon_ev.tag, "_rise"}, rise, mon_ev.rise);
        chk({mon_ev.tag, "_fall"}, fall, mon_ev.fall);
        chk({mon_ev.tag, "_long"}, lng, mon_ev.lng);
      end else begin
        chk("no_pulse", rise | fall | lng, 4'b0);
      end
      chk("level", deb, exp_deb);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int c, input logic [3:0] r, input logic [3:0] f,
                      input logic [3:0] l, input logic clr, input string tag);
    ev_t e;
    plan_deb = clr ? 4'b0 : ((plan_deb | r) & ~f);
    e.cyc  = c;
    e.rise = r;
    e.fall = f;
    e.lng  = l;
    e.deb  = plan_deb;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic wait_quiet(input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL timeout cyc=%0d observed_pending=%0d expected_pending=0", cyc, sb.size());
    end
    #1;
  endtask

  initial begin
    int c;

    // Reset for three edges; all outputs must read zero.
    push(1, 4'b0, 4'b0, 4'b0, 1'b1, "reset");
    step(3);
    rst = 1'b0;
    step(2);

    // Clean press on channel 0.
    c = cyc;
    bounced[0] = 1'b1;
    push(c + 10, 4'b0001, 4'b0, 4'b0, 1'b0, "press0");
    push(c + 42, 4'b0, 4'b0, 4'b0001, 1'b0, "long0");
    wait_quiet(60);
    step(3);

    // Bounce on channel 1: 3 high, 5 low, 2 high, 6 low, then settled low.
    bounced[1] = 1'b1; step(3);
    bounced[1] = 1'b0; step(5);
    bounced[1] = 1'b1; step(2);
    bounced[1] = 1'b0; step(6);
    step(15);

    // Simultaneous press of channels 1..3, then release of all four.
    c = cyc;
    bounced[3:1] = 3'b111;
    push(c + 10, 4'b1110, 4'b0, 4'b0, 1'b0, "press123");
    push(c + 42, 4'b0, 4'b0, 4'b1110, 1'b0, "long123");
    wait_quiet(60);
    step(3);
    c = cyc;
    bounced = '0;
    push(c + 10, 4'b0, 4'b1111, 4'b0, 1'b0, "release_all");
    wait_quiet(20);
    step(3);

    // Enable freeze after 4 counted cycles, 20 frozen cycles.
    c = cyc;
    bounced[0] = 1'b1;
    push(c + 30, 4'b0001, 4'b0, 4'b0, 1'b0, "freeze_accept");
    push(c + 62, 4'b0, 4'b0, 4'b0001, 1'b0, "freeze_long");
    step(6);
    enable = 1'b0;
    step(20);
    enable = 1'b1;
    wait_quiet(60);
    step(3);
    c = cyc;
    bounced[0] = 1'b0;
    push(c + 10, 4'b0, 4'b0001, 4'b0, 1'b0, "freeze_release");
    wait_quiet(20);
    step(3);

    // Threshold 0: a one-cycle glitch on channel 3 is accepted.
    thr = 16'd0;
    step(2);
    c = cyc;
    push(c + 3, 4'b1000, 4'b0, 4'b0, 1'b0, "glitch_rise");
    push(c + 4, 4'b0, 4'b1000, 4'b0, 1'b0, "glitch_fall");
    bounced[3] = 1'b1;
    step(1);
    bounced[3] = 1'b0;
    wait_quiet(20);
    thr = 16'd8;
    step(3);

    // Threshold dropped from 8 to 2 while channel 2 has counted 5.
    c = cyc;
    push(c + 8, 4'b0100, 4'b0, 4'b0, 1'b0, "thr_drop");
    push(c + 18, 4'b0, 4'b0100, 4'b0, 1'b0, "thr_release");
    bounced[2] = 1'b1;
    step(7);
    thr = 16'd2;
    step(1);
    thr = 16'd8;
    bounced[2] = 1'b0;
    wait_quiet(30);
    step(3);

    // Reset mid-hold (channel 0) and mid-check (channel 2).
    c = cyc;
    bounced[0] = 1'b1;
    push(c + 10, 4'b0001, 4'b0, 4'b0, 1'b0, "pre_reset_press0");
    step(20);
    c = cyc;
    bounced[2] = 1'b1;
    push(c + 6, 4'b0, 4'b0, 4'b0, 1'b1, "reset_edge");
    push(c + 16, 4'b0101, 4'b0, 4'b0, 1'b0, "requalify");
    push(c + 48, 4'b0, 4'b0, 4'b0101, 1'b0, "requalify_long");
    step(5);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_quiet(60);
    step(3);
    c = cyc;
    bounced = '0;
    push(c + 10, 4'b0, 4'b0101, 4'b0, 1'b0, "final_release");
    wait_quiet(20);
    step(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debouncer_multi.md
DEBOUNCER_MULTI -- requirements
Module: debouncer_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, range 1..32.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stability and hold counters.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel, minimum 2.
REQ-004 SHALL have parameter LONG_CYCLES, default 50000: stable-high cycles before a long-press pulse, range 1..2^CNT_W-1.
REQ-005 SHALL have port clock, input, 1 bit: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: high lets channel state advance; low freezes it.
REQ-008 SHALL have port threshold_i, input, CNT_W bits: required stable cycles; a value of 0 behaves as 1.
REQ-009 SHALL have port bounced_i, input, N_CH bits: raw asynchronous button inputs.
REQ-010 SHALL have port debounced_o, output, N_CH bits: debounced level, registered.
REQ-011 SHALL have port rise_o, output, N_CH bits: one-cycle pulse when debounced_o goes 0->1.
REQ-012 SHALL have port fall_o, output, N_CH bits: one-cycle pulse when debounced_o goes 1->0.
REQ-013 SHALL have port long_o, output, N_CH bits: one-cycle pulse, once per press, after LONG_CYCLES of stable high.

Function
REQ-014 Each channel SHALL pass bounced_i[k] through a chain of SYNC_STAGES flops; the output of that chain is sync[k].
- The synchroniser SHALL run regardless of enable.
REQ-015 Each channel SHALL have a four-state FSM: LOW, CHK_HIGH, HIGH, CHK_LOW.
REQ-016 FSM transitions:
- LOW -> CHK_HIGH when sync=1.
- CHK_HIGH -> LOW when sync=0.
- CHK_HIGH -> HIGH when sync=1 and stab_cnt+1 >= max(threshold_i,1).
- HIGH and CHK_LOW mirror these rules with the polarity inverted.
REQ-017 stab_cnt SHALL behave as follows:
- Cleared on entry to LOW or HIGH.
- Incremented each cycle in a CHK state while sync differs from debounced_o.
- Saturates at 2^CNT_W-1 and never wraps.
REQ-018 debounced_o[k] SHALL be 1 exactly when the FSM is in HIGH or CHK_LOW.
- Latency: a clean input edge held stable appears at debounced_o SYNC_STAGES+max(threshold_i,1) cycles later.
REQ-019 rise_o[k]/fall_o[k] SHALL assert in the same cycle debounced_o[k] first shows the new level, for exactly one cycle.
REQ-020 hold_cnt[k] SHALL behave as follows:
- Cleared when debounced_o[k]=0.
- Incremented each enabled cycle while debounced_o[k]=1.
- Saturates at LONG_CYCLES.
- long_o[k] pulses for one cycle on the cycle hold_cnt reaches LONG_CYCLES, and not again until a new press.
REQ-021 threshold_i SHALL be sampled live every cycle.
- A threshold lowered below the current stab_cnt SHALL cause acceptance on the next cycle the input still differs.
REQ-022 With enable=0:
- FSM, stab_cnt and hold_cnt SHALL hold their values.
- rise_o, fall_o and long_o SHALL be 0.
- debounced_o SHALL hold its value.
REQ-023 Channels SHALL be fully independent; simultaneous events on any subset SHALL produce per-channel pulses in the same cycle.
REQ-024 A bounce that returns to the accepted level before the threshold is reached SHALL produce no output change and no pulse.

Reset
REQ-025 On reset=1 at a clock edge, the following SHALL be applied at that edge, overriding enable:
- FSMs go to LOW.
- stab_cnt, hold_cnt and synchroniser flops go to 0.
- debounced_o, rise_o, fall_o and long_o go to 0.
REQ-026 Reset asserted mid-check or mid-hold SHALL discard the pending state with no pulse emitted; after release, a held-high input is re-qualified from LOW.

Verification
REQ-027 Common bench settings: N_CH=4, SYNC_STAGES=2, LONG_CYCLES=32, threshold_i=8, enable=1, 20 ns clock. The bench SHALL cover the following scenarios.
REQ-028 Clean press:
- Stimulus: bounced_i[0] 0->1 and held for 40 cycles.
- Response: debounced_o[0]=1 and rise_o[0] pulse exactly 10 cycles after the edge.
- Response: long_o[0] single pulse 32 cycles after that.
REQ-029 Bounce reject:
- Stimulus: bounced_i[1] toggles with high/low times of 3, 5, 2 and 6 cycles, then settles at 0.
- Response: debounced_o[1] stays 0; rise_o and fall_o stay 0.
REQ-030 Simultaneous release:
- Stimulus: channels 0..3 all debounced high, then all inputs drop in the same cycle.
- Response: fall_o=4'hF for one cycle, 10 cycles later.
REQ-031 Enable freeze:
- Stimulus: enable=0 after 4 stable cycles of a new level, held for 20 cycles, then enable=1.
- Response: acceptance occurs 4 enabled cycles after enable returns; no pulses while enable=0.
REQ-032 Threshold edge cases:
- Stimulus: threshold_i=0 with a 1-cycle glitch.
- Response: glitch accepted, with debounced_o change 3 cycles after it.
- Stimulus: threshold_i lowered from 8 to 2 while stab_cnt=5.
- Response: accepted on the next cycle.
REQ-033 Reset mid-check:
- Stimulus: reset pulsed for 1 cycle while channel 2 is in CHK_HIGH, with the input held high.
- Response: all outputs 0 on that edge; rise_o[2] pulse 10 cycles after reset is released.
